lsu_mem_master: RTL and testbench
=================================

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have parameter TRANSFER_WIDTH, default 4, byte-strobe width (DATA_WIDTH/8).
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid_i in 1 / req_ready_o out 1, CPU request handshake.
REQ-007 SHALL have ports req_we_i in 1 (1 store, 0 load), req_size_i in 2 (00 byte, 01 half, 10 word, 11 illegal), req_signed_i in 1 (load sign-extend).
REQ-008 SHALL have ports req_addr_i in ADDR_WIDTH and req_wdata_i in DATA_WIDTH (store data, right-justified).
REQ-009 SHALL have ports rsp_valid_o out 1 / rsp_ready_i in 1, response handshake; rsp_rdata_o out DATA_WIDTH; rsp_err_o out 1.
REQ-010 SHALL have memory-side ports mem_we_o out 1, mem_addr_o out ADDR_WIDTH, mem_wdata_o out DATA_WIDTH, mem_transfer_o out TRANSFER_WIDTH, mem_rdata_i in DATA_WIDTH (combinational read, valid same cycle when mem_we_o=0).

Function
REQ-011 SHALL implement FSM IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
REQ-012 SHALL assert req_ready_o only in IDLE; request accepted when req_valid_i && req_ready_o, fields registered.
REQ-013 SHALL drive, in ACC0, mem_addr_o = {addr[ADDR_WIDTH-1:2],2'b00} and, for stores, mem_we_o=1, mem_wdata_o = wdata << (8*addr[1:0]).
REQ-014 SHALL set store strobe: byte 0001<<off, half 0011<<off, word 1111, truncated to TRANSFER_WIDTH bits; loads drive mem_we_o=0, mem_transfer_o=0.
REQ-015 SHALL capture mem_rdata_i at end of each load access cycle.
REQ-016 SHALL form load data by shifting captured word right by 8*off, masking to size, then sign-extending if req_signed_i else zero-extending.
REQ-017 SHALL in RESP hold rsp_valid_o=1 and rsp_rdata_o/rsp_err_o stable until rsp_ready_i; return to IDLE on that cycle.
REQ-018 SHALL give aligned latency: accept at cycle N, ACC0 at N+1, rsp_valid_o at N+2.
REQ-019 SHALL classify misaligned: half with off=3, word with off!=0.
REQ-020 SHALL treat req_size_i=11 as error: no memory access in ACC0 (we=0, transfer=0), rsp_err_o=1, rsp_rdata_o=0.
REQ-021 SHALL for stores return rsp_rdata_o=0, rsp_err_o=0.
REQ-022 SHALL compute second-word address modulo 2^ADDR_WIDTH (wrap from top word to word 0).
REQ-023 SHALL drive mem_we_o=0, mem_transfer_o=0, mem_addr_o=0, mem_wdata_o=0 outside ACC0/ACC1.

Reset
REQ-024 SHALL on rst_n=0 go to IDLE immediately; req_ready_o=1 after release, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, memory outputs 0.
REQ-025 SHALL discard any in-flight request or pending response on reset; no partial second access issued after release.

Configuration
REQ-026 SHALL use macro LSU_MISALIGNED_SPLIT_EN.
REQ-027 SHALL, when defined, split misaligned accesses: ACC0 lower word with in-word strobe bits, ACC1 next word with remaining bits and wdata >> (8*(4-off)); load combines both words; rsp_valid_o at N+3; rsp_err_o=0.
REQ-028 SHALL, when undefined, treat misaligned as REQ-020 error (no access, err=1, latency N+2); ACC1 state not built.

Structure
REQ-029 SHALL place size encodings, FSM state encoding and strobe base masks in shared package lsu_pkg.
REQ-030 SHALL factor combinational strobe/shift/extend logic into sub-module lsu_align; FSM and registers stay in lsu_mem_master.

Verification
REQ-031 Store word 0xDEADBEEF @0x010 -> one ACC0 cycle, mem_addr_o=0x010, transfer=1111; load word @0x010 -> rdata 0xDEADBEEF at N+2.
REQ-032 Store byte 0x80 @0x013 -> transfer=1000, wdata=0x80000000; signed load byte @0x013 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-033 Store half 0x1234 @0x022 -> transfer=1100, wdata=0x12340000; rsp_ready_i held 0 for 3 cycles -> rsp_valid_o and data stable, req_ready_o=0.
REQ-034 Word store 0xAABBCCDD @0x031: split build -> ACC0 addr 0x030 transfer=1110, ACC1 addr 0x034 transfer=0001, readback 0xAABBCCDD; non-split -> no access, rsp_err_o=1.
REQ-035 Split word load @0x3FE (ADDR_WIDTH=10) -> ACC1 addr 0x000; req_size_i=11 -> err=1, rdata 0, no mem_we_o pulse.
REQ-036 rst_n pulsed low during ACC0 of split store -> no ACC1, rsp_valid_o=0, req_ready_o=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store memory master: access size
// encodings, FSM state encoding, byte-strobe base masks and a helper that
// classifies misaligned accesses.
// ---------------------------------------------------------------------------
package lsu_pkg;

  // Access size encodings carried on req_size_i.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // FSM state encoding. ST_ACC1 is only reachable in the split build.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Byte-strobe base masks before shifting by the byte offset.
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;
  localparam logic [3:0] STRB_NONE = 4'b0000;

  // Base strobe for a given size; illegal size enables no bytes.
  function automatic logic [3:0] base_strobe(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return STRB_BYTE;
      SIZE_HALF: return STRB_HALF;
      SIZE_WORD: return STRB_WORD;
      default:   return STRB_NONE;
    endcase
  endfunction

  // An access is misaligned when it crosses a word boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_HALF: return (off == 2'd3);
      SIZE_WORD: return (off != 2'd0);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational alignment datapath for the memory master. Produces the word
// address, byte strobe and shifted store data for either the lower word
// (hi_word_i=0) or the following word (hi_word_i=1), and builds the
// right-justified, size-masked, sign/zero-extended load result from the two
// memory words.
// Ports:
//   size_i, sign_ext_i, addr_i, wdata_i : registered request fields
//   hi_word_i                           : select second-word view
//   rdata_lo_i, rdata_hi_i              : lower / upper memory words
//   word_addr_o, strobe_o, wdata_o      : memory-side access values
//   rdata_o                             : formatted load data
//   misaligned_o, illegal_o             : request classification
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4
) (
  input  logic [1:0]                size_i,
  input  logic                      sign_ext_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      hi_word_i,
  input  logic [DATA_WIDTH-1:0]     rdata_lo_i,
  input  logic [DATA_WIDTH-1:0]     rdata_hi_i,
  output logic [ADDR_WIDTH-1:0]     word_addr_o,
  output logic [TRANSFER_WIDTH-1:0] strobe_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      misaligned_o,
  output logic                      illegal_o
);

  logic [1:0]                  off_s;
  logic [ADDR_WIDTH-1:0]       base_addr_s;
  logic [2*TRANSFER_WIDTH-1:0] strb_wide_s;
  logic [2*DATA_WIDTH-1:0]     wdata_wide_s;
  logic [2*DATA_WIDTH-1:0]     rdata_wide_s;
  logic [DATA_WIDTH-1:0]       rdata_shift_s;

  assign off_s        = addr_i[1:0];
  assign misaligned_o = is_misaligned(size_i, off_s);
  assign illegal_o    = (size_i == SIZE_ILL);

  // Double-width shifts: the lower half is the in-word part, the upper half
  // is what spills into the next word.
  always_comb begin
    base_addr_s   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    strb_wide_s   = {{TRANSFER_WIDTH{1'b0}}, TRANSFER_WIDTH'(base_strobe(size_i))} << off_s;
    wdata_wide_s  = {{DATA_WIDTH{1'b0}}, wdata_i} << {off_s, 3'b000};
    rdata_wide_s  = {rdata_hi_i, rdata_lo_i} >> {off_s, 3'b000};
    rdata_shift_s = rdata_wide_s[DATA_WIDTH-1:0];
  end

  // Select lower-word or next-word view; next word wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    if (hi_word_i) begin
      word_addr_o = base_addr_s + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
      strobe_o    = strb_wide_s[2*TRANSFER_WIDTH-1:TRANSFER_WIDTH];
      wdata_o     = wdata_wide_s[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      word_addr_o = base_addr_s;
      strobe_o    = strb_wide_s[TRANSFER_WIDTH-1:0];
      wdata_o     = wdata_wide_s[DATA_WIDTH-1:0];
    end
  end

  // Mask the right-justified load data to size and extend.
  always_comb begin
    case (size_i)
      SIZE_BYTE: rdata_o = {{(DATA_WIDTH-8){sign_ext_i & rdata_shift_s[7]}}, rdata_shift_s[7:0]};
      SIZE_HALF: rdata_o = {{(DATA_WIDTH-16){sign_ext_i & rdata_shift_s[15]}}, rdata_shift_s[15:0]};
      SIZE_WORD: rdata_o = rdata_shift_s;
      default:   rdata_o = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
// Load/store unit memory master. Accepts one CPU request at a time, performs
// one (or, for a misaligned access in the split build, two) word accesses to
// a combinational-read memory and returns a registered response.
// FSM: IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
// Configuration macro: LSU_MISALIGNED_SPLIT_EN
//   defined   : misaligned accesses are split over two word accesses
//   undefined : misaligned accesses are rejected with rsp_err_o=1
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   req_valid_i / req_ready_o        : request handshake
//   req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i : request
//   rsp_valid_o / rsp_ready_i        : response handshake
//   rsp_rdata_o, rsp_err_o           : response payload
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_transfer_o, mem_rdata_i : memory
// ---------------------------------------------------------------------------
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_signed_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [TRANSFER_WIDTH-1:0] mem_transfer_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  logic [1:0]                state_r;
  logic                      we_r;
  logic [1:0]                size_r;
  logic                      sign_r;
  logic [ADDR_WIDTH-1:0]     addr_r;
  logic [DATA_WIDTH-1:0]     wdata_r;
  logic                      rsp_valid_r;
  logic [DATA_WIDTH-1:0]     rsp_rdata_r;
  logic                      rsp_err_r;

  logic                      hi_word_s;
  logic                      reject_s;
  logic                      split_s;
  logic                      misaligned_s;
  logic                      illegal_s;
  logic [DATA_WIDTH-1:0]     rdata_lo_s;
  logic [ADDR_WIDTH-1:0]     word_addr_s;
  logic [TRANSFER_WIDTH-1:0] strobe_s;
  logic [DATA_WIDTH-1:0]     wdata_al_s;
  logic [DATA_WIDTH-1:0]     load_data_s;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [DATA_WIDTH-1:0]     rdata_lo_r;

  // In ACC1 the lower word was captured in ACC0; the live read is the upper.
  assign hi_word_s  = (state_r == ST_ACC1);
  assign rdata_lo_s = hi_word_s ? rdata_lo_r : mem_rdata_i;
  assign reject_s   = illegal_s;
  assign split_s    = misaligned_s;
`else
  assign hi_word_s  = 1'b0;
  assign rdata_lo_s = mem_rdata_i;
  assign reject_s   = illegal_s | misaligned_s;
  assign split_s    = 1'b0;
`endif

  lsu_align #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .TRANSFER_WIDTH (TRANSFER_WIDTH)
  ) u_align (
    .size_i       (size_r),
    .sign_ext_i   (sign_r),
    .addr_i       (addr_r),
    .wdata_i      (wdata_r),
    .hi_word_i    (hi_word_s),
    .rdata_lo_i   (rdata_lo_s),
    .rdata_hi_i   (mem_rdata_i),
    .word_addr_o  (word_addr_s),
    .strobe_o     (strobe_s),
    .wdata_o      (wdata_al_s),
    .rdata_o      (load_data_s),
    .misaligned_o (misaligned_s),
    .illegal_o    (illegal_s)
  );

  assign req_ready_o = (state_r == ST_IDLE);
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;

  // Memory port is quiet except during an accepted access cycle.
  always_comb begin
    mem_we_o       = 1'b0;
    mem_addr_o     = {ADDR_WIDTH{1'b0}};
    mem_wdata_o    = {DATA_WIDTH{1'b0}};
    mem_transfer_o = {TRANSFER_WIDTH{1'b0}};
    if (((state_r == ST_ACC0) || (state_r == ST_ACC1)) && !reject_s) begin
      mem_addr_o     = word_addr_s;
      mem_we_o       = we_r;
      mem_wdata_o    = we_r ? wdata_al_s : {DATA_WIDTH{1'b0}};
      mem_transfer_o = we_r ? strobe_s : {TRANSFER_WIDTH{1'b0}};
    end else begin
      mem_we_o       = 1'b0;
      mem_transfer_o = {TRANSFER_WIDTH{1'b0}};
    end
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  // Capture the lower word of a split load at the end of ACC0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_lo_r <= {DATA_WIDTH{1'b0}};
    end else if ((state_r == ST_ACC0) && split_s && !we_r) begin
      rdata_lo_r <= mem_rdata_i;
    end
  end
`endif

  // Request FSM, registered request fields and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      size_r      <= SIZE_BYTE;
      sign_r      <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_r    <= req_we_i;
            size_r  <= req_size_i;
            sign_r  <= req_signed_i;
            addr_r  <= req_addr_i;
            wdata_r <= req_wdata_i;
            state_r <= ST_ACC0;
          end
        end
        ST_ACC0: begin
          if (reject_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            state_r     <= ST_RESP;
          end else if (split_s) begin
            state_r <= ST_ACC1;
          end else begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= we_r ? {DATA_WIDTH{1'b0}} : load_data_s;
            state_r     <= ST_RESP;
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ST_ACC1: begin
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= we_r ? {DATA_WIDTH{1'b0}} : load_data_s;
          state_r     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_master
// Directed bench for lsu_mem_master with a byte-strobed word memory model.
// Expected values are hand-computed constants; misaligned expectations
// follow the LSU_MISALIGNED_SPLIT_EN build setting.
// ---------------------------------------------------------------------------
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_signed_i = 1'b0;
  logic [9:0]  req_addr_i = 10'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_transfer_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0]  acc_addr [0:8];
  logic [3:0]  acc_tr   [0:8];
  logic [31:0] acc_wd   [0:8];
  logic        acc_we   [0:8];
  int          lat_g;
  int          we_pulses_g;
  logic [31:0] rsp_data_g;
  logic        rsp_err_g;

  lsu_mem_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_signed_i   (req_signed_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_transfer_o (mem_transfer_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Combinational-read, byte-strobed write memory.
  assign mem_rdata_i = mem[mem_addr_o[9:2]];

  always @(posedge clk) begin
    if (mem_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_transfer_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request; records each access cycle, latency and response; holds
  // rsp_ready_i low for 'hold' extra cycles while checking stability.
  task automatic transact(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [9:0] addr, input logic [31:0] wdata, input int hold);
    logic done;
    @(negedge clk);
    check_eq("ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_size_i   = size;
    req_signed_i = sgn;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    lat_g = 0;
    we_pulses_g = 0;
    done = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!done) begin
        @(negedge clk);
        if (rsp_valid_o) begin
          lat_g = k;
          done = 1'b1;
        end else begin
          acc_addr[k] = mem_addr_o;
          acc_tr[k]   = mem_transfer_o;
          acc_wd[k]   = mem_wdata_o;
          acc_we[k]   = mem_we_o;
          if (mem_we_o) we_pulses_g++;
        end
      end
    end
    if (!done) check_eq("rsp_timeout", 32'd0, 32'd1);
    rsp_data_g = rsp_rdata_o;
    rsp_err_g  = rsp_err_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      check_eq("hold_data", rsp_rdata_o, rsp_data_g);
      check_eq("hold_ready", {31'd0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    check_eq("rsp_drop", {31'd0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[255] = 32'h5566_7788;
    mem[0]   = 32'h1122_3344;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check_eq("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_eq("rst_rdata", rsp_rdata_o, 32'd0);
    check_eq("rst_err", {31'd0, rsp_err_o}, 32'd0);
    check_eq("rst_mem", {mem_we_o, mem_transfer_o, 17'd0, mem_addr_o}, 32'd0);
    check_eq("rst_wdata", mem_wdata_o, 32'd0);

    // Aligned word store and load.
    transact(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEAD_BEEF, 0);
    check_eq("sw_lat", lat_g, 32'd2);
    check_eq("sw_addr", {22'd0, acc_addr[1]}, 32'h010);
    check_eq("sw_tr", {28'd0, acc_tr[1]}, 32'hF);
    check_eq("sw_wd", acc_wd[1], 32'hDEAD_BEEF);
    check_eq("sw_we", {31'd0, acc_we[1]}, 32'd1);
    check_eq("sw_rsp", {rsp_err_g, rsp_data_g[30:0]}, 32'd0);
    transact(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, 0);
    check_eq("lw_lat", lat_g, 32'd2);
    check_eq("lw_we", {28'd0, acc_tr[1]} | {31'd0, acc_we[1]}, 32'd0);
    check_eq("lw_data", rsp_data_g, 32'hDEAD_BEEF);

    // Byte store to offset 3, then signed and unsigned loads.
    transact(1'b1, 2'b00, 1'b0, 10'h013, 32'h0000_0080, 0);
    check_eq("sb_tr", {28'd0, acc_tr[1]}, 32'h8);
    check_eq("sb_wd", acc_wd[1], 32'h8000_0000);
    transact(1'b0, 2'b00, 1'b1, 10'h013, 32'd0, 0);
    check_eq("lb_s", rsp_data_g, 32'hFFFF_FF80);
    transact(1'b0, 2'b00, 1'b0, 10'h013, 32'd0, 0);
    check_eq("lb_u", rsp_data_g, 32'h0000_0080);

    // Half store with response back-pressure, then readback.
    transact(1'b1, 2'b01, 1'b0, 10'h022, 32'h0000_1234, 3);
    check_eq("sh_tr", {28'd0, acc_tr[1]}, 32'hC);
    check_eq("sh_wd", acc_wd[1], 32'h1234_0000);
    transact(1'b0, 2'b01, 1'b0, 10'h022, 32'd0, 0);
    check_eq("lh_u", rsp_data_g, 32'h0000_1234);

    // In-word half at offset 1, signed readback.
    transact(1'b1, 2'b01, 1'b0, 10'h045, 32'h0000_BEEF, 0);
    check_eq("sh1_tr", {28'd0, acc_tr[1]}, 32'h6);
    check_eq("sh1_wd", acc_wd[1], 32'h00BE_EF00);
    transact(1'b0, 2'b01, 1'b1, 10'h045, 32'd0, 0);
    check_eq("lh1_s", rsp_data_g, 32'hFFFF_BEEF);

    // Misaligned word store / load.
    transact(1'b1, 2'b10, 1'b0, 10'h031, 32'hAABB_CCDD, 0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check_eq("msw_lat", lat_g, 32'd3);
    check_eq("msw_a0", {22'd0, acc_addr[1]}, 32'h030);
    check_eq("msw_t0", {28'd0, acc_tr[1]}, 32'hE);
    check_eq("msw_w0", acc_wd[1], 32'hBBCC_DD00);
    check_eq("msw_a1", {22'd0, acc_addr[2]}, 32'h034);
    check_eq("msw_t1", {28'd0, acc_tr[2]}, 32'h1);
    check_eq("msw_w1", acc_wd[2], 32'h0000_00AA);
    check_eq("msw_err", {31'd0, rsp_err_g}, 32'd0);
    transact(1'b0, 2'b10, 1'b0, 10'h031, 32'd0, 0);
    check_eq("mlw_data", rsp_data_g, 32'hAABB_CCDD);
    transact(1'b0, 2'b10, 1'b0, 10'h3FE, 32'd0, 0);
    check_eq("wrap_a1", {22'd0, acc_addr[2]}, 32'h000);
    check_eq("wrap_data", rsp_data_g, 32'h3344_5566);
`else
    check_eq("msw_lat", lat_g, 32'd2);
    check_eq("msw_err", {31'd0, rsp_err_g}, 32'd1);
    check_eq("msw_rdata", rsp_data_g, 32'd0);
    check_eq("msw_we", we_pulses_g, 32'd0);
    check_eq("msw_tr", {28'd0, acc_tr[1]}, 32'd0);
    transact(1'b0, 2'b10, 1'b0, 10'h3FE, 32'd0, 0);
    check_eq("wrap_err", {31'd0, rsp_err_g}, 32'd1);
    check_eq("wrap_addr", {22'd0, acc_addr[1]}, 32'd0);
`endif

    // Illegal size: no access, error response.
    transact(1'b1, 2'b11, 1'b0, 10'h040, 32'hFFFF_FFFF, 0);
    check_eq("ill_lat", lat_g, 32'd2);
    check_eq("ill_we", we_pulses_g, 32'd0);
    check_eq("ill_err", {31'd0, rsp_err_g}, 32'd1);
    check_eq("ill_rdata", rsp_data_g, 32'd0);
    transact(1'b0, 2'b11, 1'b1, 10'h040, 32'd0, 0);
    check_eq("ill_lerr", {31'd0, rsp_err_g}, 32'd1);
    check_eq("ill_ldata", rsp_data_g, 32'd0);

    // Reset during ACC0 of a misaligned store.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = 2'b10;
    req_addr_i  = 10'h051;
    req_wdata_i = 32'h1111_1111;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_we", {31'd0, mem_we_o}, 32'd0);
    check_eq("arst_valid", {31'd0, rsp_valid_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we_pulses_g = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we_o) we_pulses_g++;
      check_eq("post_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
      check_eq("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    end
    check_eq("post_rst_we", we_pulses_g, 32'd0);
    check_eq("post_rst_mem", mem[20], 32'd0);

    // Normal operation after reset.
    transact(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, 0);
    check_eq("post_lw", rsp_data_g, 32'h80AD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
